// File: rtl/sbus_pkg.sv
// Shared SBUS read types: initiator state encoding, address/mask/word typedefs
// and the 36-bit data parity helper.
package sbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } tSbusRdState;

  typedef logic [14:35] tSbusAdr;
  typedef logic [0:3]   tSbusRq;
  typedef logic [0:35]  tWord;
  typedef logic [34:35] tWordIdx;

  // Even parity over a full SBUS data word (DATA_PAR is the XOR of D[0:35]).
  function automatic logic sbus_par36(input tWord w);
    return ^w;
  endfunction

endpackage

// File: rtl/sbus_read_initiator_if.sv
// Request, SBUS and word-return signals of one memory-phase read initiator.
// master is the initiator's view; slave is the MBOX/responder side.
interface sbus_read_initiator_if;
  import sbus_pkg::*;

  logic    reqValid;
  logic    reqReady;
  tSbusAdr reqAdr;
  tSbusRq  reqRQ;

  logic    START;
  tSbusAdr ADR;
  tSbusRq  RQ;
  logic    ACKN;
  logic    VALID;
  tWord    D;
  logic    DATA_PAR;

  logic    wordValid;
  tWord    wordData;
  tWordIdx wordIdx;
  logic    wordParErr;
  logic    done;
  logic    nxm;
  logic    parErr;

  modport master (
    input  reqValid, reqAdr, reqRQ, ACKN, VALID, D, DATA_PAR,
    output reqReady, START, ADR, RQ, wordValid, wordData, wordIdx, wordParErr,
           done, nxm, parErr
  );

  modport slave (
    output reqValid, reqAdr, reqRQ, ACKN, VALID, D, DATA_PAR,
    input  reqReady, START, ADR, RQ, wordValid, wordData, wordIdx, wordParErr,
           done, nxm, parErr
  );

endinterface

// File: rtl/sbus_ack_timer.sv
// ACKN wait counter: counts cycles spent waiting on an expected word and flags
// expiry once the count reaches TIMEOUT-1.
module sbus_ack_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic CROBAR,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/sbus_read_initiator_chk.sv
// Protocol invariants of the read initiator outputs.
module sbus_read_initiator_chk (
  input logic clk,
  input logic CROBAR,
  input logic START,
  input logic done,
  input logic wordValid,
  input logic reqReady
);

  a_start_single: assert property (@(posedge clk) disable iff (CROBAR) START |=> !START);
  a_done_single:  assert property (@(posedge clk) disable iff (CROBAR) done |=> !done);
  a_start_busy:   assert property (@(posedge clk) disable iff (CROBAR) START |-> !reqReady);
  a_done_busy:    assert property (@(posedge clk) disable iff (CROBAR) done |-> !reqReady);
  a_word_busy:    assert property (@(posedge clk) disable iff (CROBAR) wordValid |-> !reqReady);

endmodule

// File: rtl/sbus_read_initiator.sv
// SBUS read initiator for one memory phase: issues a single-cycle START with
// ADR/RQ, then walks the word mask collecting ACKN'd words with parity and NXM.
module sbus_read_initiator
  import sbus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   CROBAR,
  sbus_read_initiator_if.master bus
);

  tSbusRdState state_q, state_d;
  tSbusAdr     adr_q, adr_d;
  tSbusRq      rq_q, rq_d;
  tSbusRq      exp_q, exp_d;
  tSbusRq      exp_next;
  logic [1:0]  wo_q, wo_d;
  logic        nxm_q, nxm_d;
  logic        perr_q, perr_d;
  logic        req_ready_q, req_ready_d;
  logic        start_q, start_d;
  logic        word_valid_q, word_valid_d;
  tWord        word_data_q, word_data_d;
  tWordIdx     word_idx_q, word_idx_d;
  logic        word_perr_q, word_perr_d;
  logic        done_q, done_d;
  logic        word_perr_now;
  logic        tmr_clr;
  logic        tmr_inc;
  logic        tmr_expire;

  // exp[0] is always the word slot currently being serviced.
  assign exp_next      = {exp_q[1:3], 1'b0};
  assign word_perr_now = (sbus_par36(bus.D) != bus.DATA_PAR);

  // Next-state and next-output logic for the request/transfer FSM.
  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    rq_d         = rq_q;
    exp_d        = exp_q;
    wo_d         = wo_q;
    nxm_d        = nxm_q;
    perr_d       = perr_q;
    start_d      = 1'b0;
    word_valid_d = 1'b0;
    word_data_d  = word_data_q;
    word_idx_d   = word_idx_q;
    word_perr_d  = word_perr_q;
    done_d       = 1'b0;
    tmr_clr      = 1'b1;
    tmr_inc      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.reqValid && req_ready_q) begin
          adr_d  = bus.reqAdr;
          rq_d   = bus.reqRQ;
          exp_d  = bus.reqRQ;
          wo_d   = bus.reqAdr[34:35];
          nxm_d  = 1'b0;
          perr_d = 1'b0;
          if (bus.reqRQ != 4'b0000) begin
            state_d = ISSUE;
            start_d = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ISSUE: begin
        state_d = XFER;
      end

      XFER: begin
        if (!exp_q[0] || (bus.ACKN && bus.VALID)) begin
          if (exp_q[0]) begin
            word_valid_d = 1'b1;
            word_data_d  = bus.D;
            word_idx_d   = wo_q;
            word_perr_d  = word_perr_now;
            perr_d       = perr_q | word_perr_now;
          end else begin
            word_valid_d = 1'b0;
          end
          exp_d = exp_next;
          wo_d  = wo_q + 2'd1;
          if (exp_next == 4'b0000) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = XFER;
          end
        end else if (tmr_expire) begin
          // Responder never acknowledged this word: give up on the request.
          nxm_d   = 1'b1;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          tmr_clr = 1'b0;
          tmr_inc = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // FSM state, request context and registered outputs.
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state_q      <= IDLE;
      adr_q        <= '0;
      rq_q         <= '0;
      exp_q        <= '0;
      wo_q         <= 2'd0;
      nxm_q        <= 1'b0;
      perr_q       <= 1'b0;
      req_ready_q  <= 1'b0;
      start_q      <= 1'b0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      word_idx_q   <= '0;
      word_perr_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      rq_q         <= rq_d;
      exp_q        <= exp_d;
      wo_q         <= wo_d;
      nxm_q        <= nxm_d;
      perr_q       <= perr_d;
      req_ready_q  <= req_ready_d;
      start_q      <= start_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      word_idx_q   <= word_idx_d;
      word_perr_q  <= word_perr_d;
      done_q       <= done_d;
    end
  end

  sbus_ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .CROBAR (CROBAR),
    .clr    (tmr_clr),
    .inc    (tmr_inc),
    .expire (tmr_expire)
  );

  sbus_read_initiator_chk u_chk (
    .clk       (clk),
    .CROBAR    (CROBAR),
    .START     (start_q),
    .done      (done_q),
    .wordValid (word_valid_q),
    .reqReady  (req_ready_q)
  );

  assign bus.reqReady   = req_ready_q;
  assign bus.START      = start_q;
  assign bus.ADR        = adr_q;
  assign bus.RQ         = rq_q;
  assign bus.wordValid  = word_valid_q;
  assign bus.wordData   = word_data_q;
  assign bus.wordIdx    = word_idx_q;
  assign bus.wordParErr = word_perr_q;
  assign bus.done       = done_q;
  assign bus.nxm        = nxm_q;
  assign bus.parErr     = perr_q;

endmodule
